// File: rtl/fdct_pkg.sv
// fdct_pkg: fixed-point constants, row/accumulator types and output rounding for the 8-point FDCT.
package fdct_pkg;
  localparam int COEF_WIDTH = 16;
  localparam int ACC_WIDTH = COEF_WIDTH + 14;
  typedef logic [7:0][COEF_WIDTH-1:0] coef_row_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  localparam acc_t C1 = 502;
  localparam acc_t C2 = 473;
  localparam acc_t C3 = 426;
  localparam acc_t C4 = 362;
  localparam acc_t C5 = 284;
  localparam acc_t C6 = 196;
  localparam acc_t C7 = 100;
  localparam acc_t ROUND = 512;
  localparam int SHIFT = 10;
  localparam acc_t MAX_C = acc_t'(2 ** (COEF_WIDTH - 1) - 1);
  localparam acc_t MIN_C = -acc_t'(2 ** (COEF_WIDTH - 1));
  // round-half-up by floor shift, then clamp to the signed coefficient range
  function automatic logic [COEF_WIDTH-1:0] sat_round(input acc_t p);
    acc_t r;
    r = (p + ROUND) >>> SHIFT;
    return r > MAX_C ? MAX_C[COEF_WIDTH-1:0] : r < MIN_C ? MIN_C[COEF_WIDTH-1:0] : r[COEF_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/stream_pipe_ctrl.sv
// stream_pipe_ctrl: valid/advance chain for a linear register pipeline with full backpressure.
module stream_pipe_ctrl #(
  parameter int STAGES = 5
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [STAGES-1:0] load
);
  logic [STAGES-1:0] valid, adv;
  logic room;
  // walk from the output back so each stage sees whether its successor frees up this cycle
  always_comb begin
    room = out_ready;
    adv = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = valid[i] && room;
      room = !valid[i] || adv[i];
    end
    in_ready = room;
    load = {adv[STAGES-2:0], in_valid && room};
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) valid <= '0;
    else valid <= load | (valid & ~adv);
  assign out_valid = valid[STAGES-1];
endmodule

// File: rtl/stream_fdct_1d.sv
// stream_fdct_1d: streaming 8-point forward 1D DCT, one row of samples in and one row of
// coefficients out per beat, five register stages with valid/ready backpressure.
module stream_fdct_1d
  import fdct_pkg::*;
#(
  parameter int COEF_WIDTH = fdct_pkg::COEF_WIDTH,
  parameter int ID_WIDTH = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*COEF_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic [8*COEF_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [COEF_WIDTH-1:0]   out_strb,
  output logic [COEF_WIDTH-1:0]   out_keep,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic [DEST_WIDTH-1:0]   out_dest,
  output logic [USER_WIDTH-1:0]   out_user
);
  localparam int N = 5;
  logic [N-1:0] ld;
  acc_t x [8];
  acc_t s1_s [4], s1_d [4], s2_e [4], s2_d [4], s3_q [4];
  acc_t s3_p [8], s4_p [8];
  logic [3:0] lst;
  coef_row_t out_row;

  stream_pipe_ctrl #(.STAGES(N)) u_ctrl (
    .aclk(aclk),
    .aresetn(aresetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .load(ld)
  );

  always_comb
    for (int i = 0; i < 8; i++) x[i] = acc_t'($signed(in_data[i*COEF_WIDTH +: COEF_WIDTH]));

  // each stage captures only when the controller loads it, so held rows stay stable
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      for (int i = 0; i < 4; i++) begin
        s1_s[i] <= '0;
        s1_d[i] <= '0;
        s2_e[i] <= '0;
        s2_d[i] <= '0;
        s3_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) begin
        s3_p[i] <= '0;
        s4_p[i] <= '0;
      end
      lst <= '0;
      out_row <= '0;
      out_last <= 1'b0;
    end else begin
      if (ld[0]) begin
        for (int i = 0; i < 4; i++) begin
          s1_s[i] <= x[i] + x[7-i];
          s1_d[i] <= x[i] - x[7-i];
        end
        lst[0] <= in_last;
      end
      if (ld[1]) begin
        s2_e[0] <= s1_s[0] + s1_s[3];
        s2_e[1] <= s1_s[1] + s1_s[2];
        s2_e[2] <= s1_s[0] - s1_s[3];
        s2_e[3] <= s1_s[1] - s1_s[2];
        s2_d <= s1_d;
        lst[1] <= lst[0];
      end
      if (ld[2]) begin
        s3_p[0] <= C4 * (s2_e[0] + s2_e[1]);
        s3_p[4] <= C4 * (s2_e[0] - s2_e[1]);
        s3_p[2] <= C2 * s2_e[2] + C6 * s2_e[3];
        s3_p[6] <= C6 * s2_e[2] - C2 * s2_e[3];
        // odd outputs split into two partial sums to keep the adder depth per stage short
        s3_p[1] <= C1 * s2_d[0] + C3 * s2_d[1];
        s3_q[0] <= C5 * s2_d[2] + C7 * s2_d[3];
        s3_p[3] <= C3 * s2_d[0] - C7 * s2_d[1];
        s3_q[1] <= -(C1 * s2_d[2]) - C5 * s2_d[3];
        s3_p[5] <= C5 * s2_d[0] - C1 * s2_d[1];
        s3_q[2] <= C7 * s2_d[2] + C3 * s2_d[3];
        s3_p[7] <= C7 * s2_d[0] - C5 * s2_d[1];
        s3_q[3] <= C3 * s2_d[2] - C1 * s2_d[3];
        lst[2] <= lst[1];
      end
      if (ld[3]) begin
        for (int k = 0; k < 8; k++) s4_p[k] <= (k % 2 == 1) ? s3_p[k] + s3_q[k/2] : s3_p[k];
        lst[3] <= lst[2];
      end
      if (ld[4]) begin
        for (int k = 0; k < 8; k++) out_row[k] <= sat_round(s4_p[k]);
        out_last <= lst[3];
      end
    end

  assign out_data = out_row;
  assign out_strb = '1;
  assign out_keep = '1;
  assign out_id = '0;
  assign out_dest = '0;
  assign out_user = '0;
endmodule

// File: tb/tb_stream_fdct_1d.sv
// tb_stream_fdct_1d: directed and randomized valid/ready traffic checked against an
// arithmetic FDCT reference model.
module tb_stream_fdct_1d;
  typedef struct {
    logic [127:0] d;
    logic [127:0] x;
    logic l;
  } beat_t;
  typedef int ints_t [8];

  logic aclk = 1'b0;
  logic aresetn;
  logic [127:0] in_data, out_data;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [15:0] out_strb, out_keep;
  logic [3:0] out_id, out_dest;
  logic [0:0] out_user;

  int checks = 0, errors = 0;
  int in_pct, out_pct, accepted = 0, out_count = 0;
  logic in_fire = 1'b0, hold_v = 1'b0;
  logic [127:0] hold_d;
  beat_t src_q [$], exp_q [$];

  stream_fdct_1d dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_strb(out_strb), .out_keep(out_keep), .out_id(out_id), .out_dest(out_dest), .out_user(out_user)
  );

  always #5 aclk = ~aclk;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack8(ints_t a);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(a[i]);
    return r;
  endfunction

  // X[k] from the fixed-point definition: even terms from the folded sums, odd terms as a 4x4 table
  function automatic logic [127:0] model(logic [127:0] d);
    longint x [8], p [8], s [4], df [4], r;
    int co [4][4];
    logic [127:0] o;
    co = '{'{502, 426, 284, 100}, '{426, -100, -502, -284}, '{284, -502, 100, 426}, '{100, -284, 426, -502}};
    for (int i = 0; i < 8; i++) x[i] = longint'($signed(d[i*16 +: 16]));
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] + x[7-i];
      df[i] = x[i] - x[7-i];
    end
    p[0] = 362 * (s[0] + s[1] + s[2] + s[3]);
    p[4] = 362 * ((s[0] + s[3]) - (s[1] + s[2]));
    p[2] = 473 * (s[0] - s[3]) + 196 * (s[1] - s[2]);
    p[6] = 196 * (s[0] - s[3]) - 473 * (s[1] - s[2]);
    for (int k = 1; k < 8; k += 2) begin
      p[k] = 0;
      for (int j = 0; j < 4; j++) p[k] += longint'(co[k/2][j]) * df[j];
    end
    for (int k = 0; k < 8; k++) begin
      r = (p[k] + 512) >>> 10;
      r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
      o[k*16 +: 16] = 16'(r);
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd_row();
    logic [127:0] d;
    for (int i = 0; i < 8; i++)
      d[i*16 +: 16] = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(4095)) - 16'd2048;
    return d;
  endfunction

  task automatic push(logic [127:0] d, logic [127:0] x, logic l);
    beat_t b;
    b.d = d;
    b.x = x;
    b.l = l;
    src_q.push_back(b);
  endtask

  // one cycle: drive at the falling edge, observe handshakes 1ns later, transfers happen at the next rising edge
  task automatic step();
    beat_t b;
    @(negedge aclk);
    if (in_fire) in_valid = 1'b0;
    if (!in_valid && src_q.size() != 0 && $urandom_range(99) < in_pct) begin
      in_data = src_q[0].d;
      in_last = src_q[0].l;
      in_valid = 1'b1;
    end
    out_ready = $urandom_range(99) < out_pct;
    #1;
    if (hold_v) begin
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_data", out_data, hold_d);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    in_fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      check("out_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("out_data", out_data, b.x);
        check("out_last", 128'(out_last), 128'(b.l));
      end
      out_count++;
    end
    if (in_fire) begin
      b = src_q.pop_front();
      exp_q.push_back(b);
      accepted++;
    end
  endtask

  task automatic drain(int bound, bit rnd);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      if (rnd) begin
        in_pct = $urandom_range(100, 20);
        out_pct = $urandom_range(100, 20);
      end
      step();
      n++;
    end
    check("drain_left", 128'(src_q.size() + exp_q.size()), '0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    in_valid = 1'b0;
    in_fire = 1'b0;
    hold_v = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), '0);
    check("mid_rst_last", 128'(out_last), '0);
    check("mid_rst_data", out_data, '0);
    exp_q.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int a0, oc0, n;
    logic [127:0] d;
    aresetn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    check("rst_out_valid", 128'(out_valid), '0);
    check("rst_out_last", 128'(out_last), '0);
    check("rst_out_data", out_data, '0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("sidebands", {out_strb, out_keep, out_id, out_dest, out_user}, {16'hffff, 16'hffff, 9'h0});

    // first-row latency: accepted at E0, visible after E4
    @(negedge aclk);
    in_data = pack8(ints_t'{default: 100});
    in_last = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("lat_in_ready", 128'(in_ready), 128'(1));
    @(posedge aclk);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      in_valid = 1'b0;
      #1;
      check("lat_valid", 128'(out_valid), 128'(i == 4));
    end
    check("lat_data", out_data, pack8(ints_t'{283, 0, 0, 0, 0, 0, 0, 0}));
    check("lat_last", 128'(out_last), 128'(1));
    @(negedge aclk);
    #1;
    check("lat_drained", 128'(out_valid), '0);

    // known-answer rows
    push(pack8(ints_t'{64, 0, 0, 0, 0, 0, 0, 0}), pack8(ints_t'{23, 31, 30, 27, 23, 18, 12, 6}), 1'b0);
    push(pack8(ints_t'{-64, 0, 0, 0, 0, 0, 0, 0}), pack8(ints_t'{-23, -31, -30, -27, -23, -18, -12, -6}), 1'b1);
    push(pack8(ints_t'{default: 32767}), pack8(ints_t'{32767, 0, 0, 0, 0, 0, 0, 0}), 1'b0);
    push(pack8(ints_t'{default: -32768}), pack8(ints_t'{-32768, 0, 0, 0, 0, 0, 0, 0}), 1'b1);
    d = pack8(ints_t'{-64, 0, 0, 0, 0, 0, 0, 0});
    push(d, model(d), 1'b0);
    in_pct = 100;
    out_pct = 100;
    drain(200, 1'b0);

    // backpressure: 8 rows, output stalled for 10 cycles
    for (int i = 0; i < 8; i++) begin
      d = rnd_row();
      push(d, model(d), i == 7);
    end
    a0 = accepted;
    oc0 = out_count;
    in_pct = 100;
    out_pct = 0;
    repeat (10) step();
    check("bp_accepted", 128'(accepted - a0), 128'(5));
    check("bp_in_ready", 128'(in_ready), '0);
    out_pct = 100;
    drain(200, 1'b0);
    check("bp_out_count", 128'(out_count - oc0), 128'(8));

    // random traffic with a reset in the middle
    for (int i = 0; i < 500; i++) begin
      d = rnd_row();
      push(d, model(d), $urandom_range(7) == 0);
    end
    a0 = accepted;
    n = 0;
    while (accepted - a0 < 250 && n < 10000) begin
      in_pct = $urandom_range(100, 20);
      out_pct = $urandom_range(100, 20);
      step();
      n++;
    end
    check("rnd_pre_reset_progress", 128'(accepted - a0 >= 250), 128'(1));
    do_reset();
    for (int i = 0; i < 500; i++) begin
      d = rnd_row();
      push(d, model(d), $urandom_range(7) == 0);
    end
    drain(20000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/stream_fdct_1d.md
Name: stream_fdct_1d

Overview:
Streaming 8-point forward 1D DCT. It is the encoder-side counterpart of the existing 1D IDCT. Each beat carries one row of 8 signed samples, and the block emits one row of 8 signed DCT coefficients per beat, with full valid/ready backpressure. Two instances with a transpose buffer between them form the 2D FDCT in the encode path.

Parameters:
COEF_WIDTH, 16, width of each signed input sample and each output coefficient.

Ports:
aclk  input  1  clock.
aresetn  input  1  asynchronous, active-low reset.
in_ch  nasti_stream_channel.slave  -  input rows.
- t_data is 8*COEF_WIDTH bits; element i sits at [i*COEF_WIDTH +: COEF_WIDTH].
- t_valid, t_ready and t_last are used; all other sidebands are ignored.
out_ch  nasti_stream_channel.master  -  output coefficient rows.
- X[k] sits at [k*COEF_WIDTH +: COEF_WIDTH].
- t_strb='1, t_keep='1, t_id/t_dest/t_user='0.

Behaviour:
- Definition: X[k] = 0.5*c(k)*sum x[n]*cos((2n+1)k*pi/16), with c(0)=1/sqrt2 and c(k)=1 otherwise. The fixed-point form below is normative; bench models must be bit-exact to it.
- Constants (scale 512): C1=502, C2=473, C3=426, C4=362, C5=284, C6=196, C7=100.
- Internal signed width is COEF_WIDTH+14. There is no intermediate truncation before the final shift.
- S1 (butterfly), i=0..3: s[i]=x[i]+x[7-i]; d[i]=x[i]-x[7-i].
- S2 (even split): e0=s0+s3, e1=s1+s2, e2=s0-s3, e3=s1-s2. d0..d3 pass through.
- S3 (products). Even products are complete:
  - P0=C4*(e0+e1); P4=C4*(e0-e1).
  - P2=C2*e2+C6*e3; P6=C6*e2-C2*e3.
- S3, odd products as two partial pairs each:
  - X1: (C1*d0+C3*d1), (C5*d2+C7*d3).
  - X3: (C3*d0-C7*d1), (-C1*d2-C5*d3).
  - X5: (C5*d0-C1*d1), (C7*d2+C3*d3).
  - X7: (C7*d0-C5*d1), (C3*d2-C1*d3).
- S4: sum the odd pairs into P1, P3, P5, P7. Even products pass through.
- S5 (output register): X[k] = sat((P[k]+512)>>>10).
  - >>> is an arithmetic shift (floor).
  - sat clamps to [-2^(COEF_WIDTH-1), 2^(COEF_WIDTH-1)-1].
- Pipeline control: S1..S4 each carry a valid flag; the S5 flag is out_ch.t_valid.
  - A stage advances when it is valid and the next stage is empty or advancing.
  - A stage flag clears when the stage advances and nothing is loaded into it.
  - The S5 advance condition is (!out_ch.t_valid || out_ch.t_ready).
  - in_ch.t_ready = !s1_valid || s1_advance. This is combinational, with no dependence on in_ch.t_valid.
- Latency: a beat accepted at edge E0 is captured in S1 at E0 and appears on out_ch after E4 (5 register stages). Throughput is 1 row/cycle while out_ch.t_ready=1.
- Backpressure:
  - With out_ch.t_ready=0 the pipe fills. At most 5 rows are held, then in_ch.t_ready drops.
  - t_data and t_last are stable while t_valid=1 and t_ready=0.
  - Bubbles collapse: a stage with valid=0 always accepts.
- t_last travels with its row through every stage. The block does no framing; rows are independent.
- Simultaneous events: a stage that empties and reloads on the same edge stays valid. No beat is dropped or duplicated.
- Reset, asserted at any time (including mid-stream):
  - All stage flags, out_ch.t_valid and out_ch.t_last go to 0 and out_ch.t_data goes to 0.
  - In-flight rows are discarded.
  - First in_ch.t_ready after release is 1.

Decomposition:
- Package fdct_pkg holds C1..C7, the rounding constant 512, the output shift 10, and the helper function sat_round(P) -> COEF_WIDTH.
- fdct_pkg also defines a coefficient-row typedef (logic [7:0][COEF_WIDTH-1:0]).
- One natural sub-module is stream_pipe_ctrl. It is parameterised by stage count, produces the per-stage valid/advance chain, the in ready and the out valid, and can be reused by a later refactor of the IDCT.
- Datapath arithmetic stays in stream_fdct_1d.

Test Plan:
- Constant row x[n]=100 for all n, out ready=1 -> X0=283, X1..X7=0; out t_valid rises after the 5th edge counting the acceptance edge.
- Impulse x0=64, others 0 -> X=[23,31,30,27,23,18,12,6].
- Impulse x0=-64 -> X=[-23,-31,-30,-27,-23,-18,-12,-6] (floor rounding: each P negated, then (P+512)>>>10). Bench checks bit-exact against the fdct_pkg model.
- Saturation: all x=32767 -> X0=32767 (unsaturated 92669). All x=-32768 -> X0=-32768. Other outputs 0.
- Backpressure: 8 back-to-back rows with out ready held 0 for 10 cycles.
  - in_ch.t_ready drops after exactly 5 accepted rows.
  - On release, all 8 rows emerge in order, values and t_last (set on row 8 only) intact, none lost or duplicated.
- Random valid/ready toggling on both sides for 1000 rows, plus aresetn pulsed mid-stream.
  - Output matches the model in order.
  - During reset, out t_valid=0 and t_last=0 immediately; no stale row is emitted after release.
